cp0_exc_unit: RTL and testbench

Coprocessor-0 exception/interrupt controller for the P7 MIPS pipeline. It is the consuming end of the 5-bit exception-code path that the execute-stage ALU drives: it collects the ExcCode carried to the M stage plus six hardware interrupt lines, and decides whether to take an exception or interrupt. On a take it latches SR/Cause/EPC and raises the flush/redirect request. It also services mfc0/mtc0/eret from the M stage.

---
 rtl/cp0_exc_unit_if.sv | 29 ++
 rtl/cp0_exc_unit.sv | 100 ++++++++++
 tb/tb_cp0_exc_unit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/cp0_exc_unit_if.sv
// Pipeline <-> CP0 exception unit bus: mfc0/mtc0/eret, M-stage exception info,
// interrupt lines, and the flush/redirect outputs.
interface cp0_exc_unit_if;
    logic [4:0]  rd_addr;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_en;
    logic [31:0] pc_m;
    logic        bd_m;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        eret_m;
    logic [31:0] rd_data;
    logic [31:0] epc_out;
    logic        req;
    logic [31:0] handler_pc;

    // Pipeline side
    modport master (
        output rd_addr, wr_addr, wr_data, wr_en, pc_m, bd_m, exc_code_in, hw_int, eret_m,
        input  rd_data, epc_out, req, handler_pc
    );

    // CP0 side
    modport slave (
        input  rd_addr, wr_addr, wr_data, wr_en, pc_m, bd_m, exc_code_in, hw_int, eret_m,
        output rd_data, epc_out, req, handler_pc
    );
endinterface

// File: rtl/cp0_exc_unit.sv
// CP0 exception/interrupt controller: decides take, latches SR/Cause/EPC,
// services mfc0/mtc0/eret from the M stage.
module cp0_exc_unit #(
    parameter logic [31:0] PRID_VAL   = 32'h0000_4D49,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input logic            clk,
    input logic            reset,
    cp0_exc_unit_if.slave  bus
);

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] epc_q, epc_d;

    logic        int_req;
    logic        exc_req;
    logic        req;
    logic [31:0] victim_pc;

    // Take decision; EXL masks both paths, interrupt beats a same-cycle exception
    always_comb begin
        int_req   = ie_q & ~exl_q & (|(bus.hw_int & im_q));
        exc_req   = ~exl_q & (bus.exc_code_in != 5'd0);
        req       = int_req | exc_req;
        victim_pc = bus.bd_m ? (bus.pc_m - 32'd4) : bus.pc_m;
    end

    // Next-state for SR/Cause/EPC
    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ip_d       = bus.hw_int;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        if (req) begin
            // The M-stage instruction is flushed, so its mtc0 must not land
            exl_d      = 1'b1;
            exc_code_d = int_req ? 5'd0 : bus.exc_code_in;
            bd_d       = bus.bd_m;
            epc_d      = {victim_pc[31:2], 2'b00};
        end else begin
            if (bus.wr_en) begin
                if (bus.wr_addr == 5'd12) begin
                    im_d  = bus.wr_data[15:10];
                    exl_d = bus.wr_data[1];
                    ie_d  = bus.wr_data[0];
                end else if (bus.wr_addr == 5'd14) begin
                    epc_d = {bus.wr_data[31:2], 2'b00};
                end
            end
            if (bus.eret_m) begin
                exl_d = 1'b0;
            end
        end
    end

    // State registers, async active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_q       <= 6'd0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= 6'd0;
            exc_code_q <= 5'd0;
            epc_q      <= 32'd0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_q       <= ip_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

    // mfc0 read mux and outputs; reads see pre-edge state (no forwarding)
    always_comb begin
        bus.rd_data = 32'd0;
        unique case (bus.rd_addr)
            5'd12:   bus.rd_data = {16'd0, im_q, 8'd0, exl_q, ie_q};
            5'd13:   bus.rd_data = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};
            5'd14:   bus.rd_data = epc_q;
            5'd15:   bus.rd_data = PRID_VAL;
            default: bus.rd_data = 32'd0;
        endcase
        bus.epc_out    = epc_q;
        bus.req        = req;
        bus.handler_pc = HANDLER_PC;
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed, table-driven bench for cp0_exc_unit.
module tb_cp0_exc_unit;

    logic clk;
    logic reset;
    cp0_exc_unit_if bus ();

    cp0_exc_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_pass;

    typedef struct {
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  exc;
        logic [5:0]  hw;
        logic        eret;
        logic [4:0]  rd_addr;
        logic        exp_req;
        logic [31:0] exp_rd;
        logic [31:0] exp_epc;
    } vec_t;

    vec_t vecs[26];

    function automatic vec_t mk(logic we, logic [4:0] wa, logic [31:0] wd, logic [31:0] pc,
                                logic bd, logic [4:0] exc, logic [5:0] hw, logic eret,
                                logic [4:0] ra, logic er, logic [31:0] erd, logic [31:0] eepc);
        vec_t v;
        v.wr_en = we; v.wr_addr = wa; v.wr_data = wd; v.pc = pc; v.bd = bd; v.exc = exc;
        v.hw = hw; v.eret = eret; v.rd_addr = ra; v.exp_req = er; v.exp_rd = erd;
        v.exp_epc = eepc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    task automatic idle_inputs();
        bus.wr_en = 1'b0; bus.wr_addr = 5'd0; bus.wr_data = 32'd0; bus.pc_m = 32'd0;
        bus.bd_m = 1'b0; bus.exc_code_in = 5'd0; bus.hw_int = 6'd0; bus.eret_m = 1'b0;
        bus.rd_addr = 5'd0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        //             we   wa     wd             pc            bd   exc    hw        er   ra     req  rd             epc
        vecs[0]  = mk(1'b1, 5'd12, 32'h0000_FC01, 32'h0,        1'b0, 5'd0, 6'b000000, 1'b0, 5'd12, 1'b0, 32'h0,         32'h0);
        vecs[1]  = mk(1'b0, 5'd0,  32'h0,         32'h0,        1'b0, 5'd0, 6'b000000, 1'b0, 5'd12, 1'b0, 32'h0000_FC01, 32'h0);
        vecs[2]  = mk(1'b1, 5'd12, 32'h0,         32'h0,        1'b0, 5'd0, 6'b000000, 1'b0, 5'd12, 1'b0, 32'h0000_FC01, 32'h0);
        vecs[3]  = mk(1'b0, 5'd0,  32'h0,         32'h0000_3010, 1'b0, 5'd12, 6'b000000, 1'b0, 5'd12, 1'b1, 32'h0,       32'h0);
        vecs[4]  = mk(1'b0, 5'd0,  32'h0,         32'h0000_3014, 1'b0, 5'd4, 6'b000000, 1'b0, 5'd13, 1'b0, 32'h0000_0030, 32'h0000_3010);
        vecs[5]  = mk(1'b0, 5'd0,  32'h0,         32'h0,        1'b0, 5'd0, 6'b000000, 1'b0, 5'd12, 1'b0, 32'h0000_0002, 32'h0000_3010);
        vecs[6]  = mk(1'b0, 5'd0,  32'h0,         32'h0,        1'b0, 5'd0, 6'b000000, 1'b1, 5'd12, 1'b0, 32'h0000_0002, 32'h0000_3010);
        vecs[7]  = mk(1'b0, 5'd0,  32'h0,         32'h0000_3020, 1'b1, 5'd5, 6'b000000, 1'b0, 5'd12, 1'b1, 32'h0,        32'h0000_3010);
        vecs[8]  = mk(1'b0, 5'd0,  32'h0,         32'h0,        1'b0, 5'd0, 6'b000000, 1'b0, 5'd13, 1'b0, 32'h8000_0014, 32'h0000_301C);
        vecs[9]  = mk(1'b0, 5'd0,  32'h0,         32'h0,        1'b0, 5'd0, 6'b000000, 1'b1, 5'd14, 1'b0, 32'h0000_301C, 32'h0000_301C);
        vecs[10] = mk(1'b1, 5'd12, 32'h0000_0401, 32'h0,        1'b0, 5'd0, 6'b000001, 1'b0, 5'd12, 1'b0, 32'h0,         32'h0000_301C);
        vecs[11] = mk(1'b0, 5'd0,  32'h0,         32'h0,        1'b0, 5'd0, 6'b000010, 1'b0, 5'd12, 1'b0, 32'h0000_0401, 32'h0000_301C);
        vecs[12] = mk(1'b0, 5'd0,  32'h0,         32'h0,        1'b0, 5'd0, 6'b000000, 1'b0, 5'd13, 1'b0, 32'h8000_0814, 32'h0000_301C);
        vecs[13] = mk(1'b1, 5'd14, 32'hDEAD_BEEF, 32'h0000_3040, 1'b0, 5'd0, 6'b000001, 1'b0, 5'd13, 1'b1, 32'h8000_0014, 32'h0000_301C);
        vecs[14] = mk(1'b0, 5'd0,  32'h0,         32'h0,        1'b0, 5'd0, 6'b000001, 1'b0, 5'd13, 1'b0, 32'h0000_0400, 32'h0000_3040);
        vecs[15] = mk(1'b0, 5'd0,  32'h0,         32'h0,        1'b0, 5'd0, 6'b000000, 1'b1, 5'd14, 1'b0, 32'h0000_3040, 32'h0000_3040);
        vecs[16] = mk(1'b0, 5'd0,  32'h0,         32'h0000_3050, 1'b0, 5'd12, 6'b000001, 1'b0, 5'd12, 1'b1, 32'h0000_0401, 32'h0000_3040);
        vecs[17] = mk(1'b0, 5'd0,  32'h0,         32'h0,        1'b0, 5'd0, 6'b000000, 1'b0, 5'd13, 1'b0, 32'h0000_0400, 32'h0000_3050);
        vecs[18] = mk(1'b0, 5'd0,  32'h0,         32'h0,        1'b0, 5'd0, 6'b000000, 1'b1, 5'd12, 1'b0, 32'h0000_0403, 32'h0000_3050);
        vecs[19] = mk(1'b0, 5'd0,  32'h0,         32'h0,        1'b1, 5'd12, 6'b000000, 1'b0, 5'd12, 1'b1, 32'h0000_0401, 32'h0000_3050);
        vecs[20] = mk(1'b1, 5'd14, 32'h1234_5677, 32'h0,        1'b0, 5'd0, 6'b000000, 1'b0, 5'd14, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        vecs[21] = mk(1'b1, 5'd13, 32'hFFFF_FFFF, 32'h0,        1'b0, 5'd0, 6'b000000, 1'b0, 5'd14, 1'b0, 32'h1234_5674, 32'h1234_5674);
        vecs[22] = mk(1'b1, 5'd12, 32'h0000_0403, 32'h0,        1'b0, 5'd0, 6'b000000, 1'b1, 5'd13, 1'b0, 32'h8000_0030, 32'h1234_5674);
        vecs[23] = mk(1'b0, 5'd0,  32'h0,         32'h0,        1'b0, 5'd0, 6'b000000, 1'b0, 5'd12, 1'b0, 32'h0000_0401, 32'h1234_5674);
        vecs[24] = mk(1'b0, 5'd0,  32'h0,         32'h0,        1'b0, 5'd0, 6'b000000, 1'b0, 5'd15, 1'b0, 32'h0000_4D49, 32'h1234_5674);
        vecs[25] = mk(1'b0, 5'd0,  32'h0,         32'h0,        1'b0, 5'd0, 6'b000000, 1'b0, 5'd7,  1'b0, 32'h0,         32'h1234_5674);

        // Reset sequencing with all interrupt lines high
        idle_inputs();
        bus.hw_int = 6'h3F;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req", {31'd0, bus.req}, 32'd0);
        chk("reset_epc_out", bus.epc_out, 32'd0);
        chk("handler_pc", bus.handler_pc, 32'h0000_4180);
        for (int a = 12; a <= 15; a++) begin
            bus.rd_addr = a[4:0];
            #1;
            chk($sformatf("reset_rd%0d", a), bus.rd_data, (a == 15) ? 32'h0000_4D49 : 32'd0);
        end
        bus.hw_int = 6'd0;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Table: drive after the edge, compare on the falling edge, then clock it in
        for (int i = 0; i < 26; i++) begin
            bus.wr_en = vecs[i].wr_en;     bus.wr_addr = vecs[i].wr_addr;
            bus.wr_data = vecs[i].wr_data; bus.pc_m = vecs[i].pc;
            bus.bd_m = vecs[i].bd;         bus.exc_code_in = vecs[i].exc;
            bus.hw_int = vecs[i].hw;       bus.eret_m = vecs[i].eret;
            bus.rd_addr = vecs[i].rd_addr;
            @(negedge clk);
            chk($sformatf("v%0d_req", i), {31'd0, bus.req}, {31'd0, vecs[i].exp_req});
            chk($sformatf("v%0d_rd", i), bus.rd_data, vecs[i].exp_rd);
            chk($sformatf("v%0d_epc", i), bus.epc_out, vecs[i].exp_epc);
            @(posedge clk);
            #1;
        end

        // Async reset mid-handler: take an exception, then pulse reset between edges
        idle_inputs();
        bus.exc_code_in = 5'd12;
        bus.pc_m = 32'h0000_5000;
        @(negedge clk);
        chk("pre_take_req", {31'd0, bus.req}, 32'd1);
        @(posedge clk);
        #1;
        bus.exc_code_in = 5'd0;
        bus.rd_addr = 5'd12;
        #1;
        chk("handler_sr", bus.rd_data, 32'h0000_0403);
        reset = 1'b0;
        #1;
        chk("async_sr", bus.rd_data, 32'd0);
        chk("async_req", {31'd0, bus.req}, 32'd0);
        chk("async_epc", bus.epc_out, 32'd0);
        bus.exc_code_in = 5'd4;
        #1;
        // With EXL cleared, a pending exception is visible again while in reset
        chk("async_exc_unmasked", {31'd0, bus.req}, 32'd1);
        bus.exc_code_in = 5'd0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_sr", bus.rd_data, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
